// File: rtl/snitch_icache_lookup_arbiter.sv
// Arbitrates fetch ports onto one lookup stage and routes responses back.
// Ports: clk_i, rst_ni, req_*, rsp_*, lk_*, lk_rsp_*, flush_*, lk_flush_*.
module snitch_icache_lookup_arbiter #(
  parameter int NR_PORTS        = 2,
  parameter int FETCH_AW        = 48,
  parameter int ID_WIDTH        = 2,
  parameter int LINE_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NR_PORTS*FETCH_AW-1:0] req_addr_i,
  input  logic [NR_PORTS-1:0]          req_valid_i,
  output logic [NR_PORTS-1:0]          req_ready_o,
  output logic [LINE_WIDTH-1:0]        rsp_data_o,
  output logic                         rsp_hit_o,
  output logic                         rsp_error_o,
  output logic [NR_PORTS-1:0]          rsp_valid_o,
  input  logic [NR_PORTS-1:0]          rsp_ready_i,
  output logic [FETCH_AW-1:0]          lk_addr_o,
  output logic [ID_WIDTH-1:0]          lk_id_o,
  output logic                         lk_valid_o,
  input  logic                         lk_ready_i,
  input  logic [ID_WIDTH-1:0]          lk_rsp_id_i,
  input  logic [LINE_WIDTH-1:0]        lk_rsp_data_i,
  input  logic                         lk_rsp_hit_i,
  input  logic                         lk_rsp_error_i,
  input  logic                         lk_rsp_valid_i,
  output logic                         lk_rsp_ready_o,
  input  logic                         flush_valid_i,
  output logic                         flush_ready_o,
  output logic                         lk_flush_valid_o,
  input  logic                         lk_flush_ready_i
);

  localparam int PW = $clog2(NR_PORTS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] lock_idx_q;
  logic          lock_q;
  logic [CW-1:0] cnt_q;

  logic [PW-1:0] gnt;
  logic          found;
  logic          can_grant;
  logic          lk_hs;
  logic          rsp_hs;
  int            idx;

  // A held grant wins over round-robin so the presented request
  // stays stable until the lookup stage accepts it.
  always_comb begin
    gnt       = lock_idx_q;
    found     = 1'b0;
    idx       = 0;
    can_grant = (state_q == IDLE) &&
                (cnt_q != CW'(MAX_OUTSTANDING));
    if (!lock_q) begin
      for (int i = 0; i < NR_PORTS; i++) begin
        idx = (int'(ptr_q) + i) % NR_PORTS;
        if (!found && req_valid_i[idx]) begin
          found = 1'b1;
          gnt   = PW'(idx);
        end
      end
    end
  end

  assign lk_valid_o = rst_ni &&
                      (lock_q || (can_grant && found));
  assign lk_addr_o  = req_addr_i[int'(gnt)*FETCH_AW +: FETCH_AW];
  assign lk_id_o    = ID_WIDTH'(gnt);
  assign lk_hs      = lk_valid_o && lk_ready_i;

  always_comb begin
    req_ready_o = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (int'(gnt) == p) begin
        req_ready_o[p] = lk_valid_o && lk_ready_i;
      end
    end
  end

  // Ids that name no port are accepted and dropped.
  always_comb begin
    rsp_valid_o    = '0;
    lk_rsp_ready_o = 1'b1;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (32'(lk_rsp_id_i) == 32'(p)) begin
        rsp_valid_o[p] = rst_ni && lk_rsp_valid_i;
        lk_rsp_ready_o = rsp_ready_i[p];
      end
    end
  end

  assign rsp_data_o  = lk_rsp_data_i;
  assign rsp_hit_o   = lk_rsp_hit_i;
  assign rsp_error_o = lk_rsp_error_i;
  assign rsp_hs      = lk_rsp_valid_i && lk_rsp_ready_o;

  always_comb begin
    state_d          = state_q;
    lk_flush_valid_o = 1'b0;
    flush_ready_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_valid_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!lock_q && cnt_q == '0) state_d = FLUSH;
      end
      FLUSH: begin
        lk_flush_valid_o = 1'b1;
        if (lk_flush_ready_i) begin
          flush_ready_o = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lk_valid_o && !lk_ready_i;
      if (lk_valid_o) lock_idx_q <= gnt;
      if (lk_hs) begin
        ptr_q <= PW'((int'(gnt) + 1) % NR_PORTS);
      end
      if (lk_hs && !rsp_hs) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!lk_hs && rsp_hs) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  a_no_rsp_underflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    rsp_hs |-> cnt_q != '0
  );

endmodule

// File: tb/tb_snitch_icache_lookup_arbiter.sv
// Randomized bench for snitch_icache_lookup_arbiter.
// Compares every cycle against a transaction-level reference model.
module tb_snitch_icache_lookup_arbiter;

  localparam int N  = 2;
  localparam int AW = 48;
  localparam int IW = 2;
  localparam int LW = 128;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [LW-1:0] rsp_data;
  logic          rsp_hit, rsp_error;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready = '0;
  logic [AW-1:0] lk_addr;
  logic [IW-1:0] lk_id;
  logic          lk_valid;
  logic          lk_ready = 1'b0;
  logic [IW-1:0] lk_rsp_id = '0;
  logic [LW-1:0] lk_rsp_data = '0;
  logic          lk_rsp_hit = 1'b0;
  logic          lk_rsp_error = 1'b0;
  logic          lk_rsp_valid = 1'b0;
  logic          lk_rsp_ready;
  logic          flush_valid = 1'b0;
  logic          flush_ready;
  logic          lk_flush_valid;
  logic          lk_flush_ready = 1'b0;

  snitch_icache_lookup_arbiter #(
    .NR_PORTS(N), .FETCH_AW(AW), .ID_WIDTH(IW),
    .LINE_WIDTH(LW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_addr_i(req_addr), .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .rsp_data_o(rsp_data), .rsp_hit_o(rsp_hit),
    .rsp_error_o(rsp_error), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .lk_addr_o(lk_addr), .lk_id_o(lk_id),
    .lk_valid_o(lk_valid), .lk_ready_i(lk_ready),
    .lk_rsp_id_i(lk_rsp_id), .lk_rsp_data_i(lk_rsp_data),
    .lk_rsp_hit_i(lk_rsp_hit), .lk_rsp_error_i(lk_rsp_error),
    .lk_rsp_valid_i(lk_rsp_valid),
    .lk_rsp_ready_o(lk_rsp_ready),
    .flush_valid_i(flush_valid), .flush_ready_o(flush_ready),
    .lk_flush_valid_o(lk_flush_valid),
    .lk_flush_ready_i(lk_flush_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: next preferred port, port whose offer is pending,
  // lookups in flight, flush phase (0 idle, 1 drain, 2 flush).
  int rr, held, inflight, phase;
  bit flush_pend;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rr = 0; held = -1; inflight = 0; phase = 0;
    flush_pend = 0;
  endtask

  task automatic do_reset();
    int id;
    @(negedge clk);
    rst_n        = 1'b0;
    req_valid    = '1;
    lk_ready     = 1'b1;
    lk_rsp_valid = 1'b1;
    lk_rsp_id    = IW'($urandom_range(0, 3));
    rsp_ready    = N'($urandom);
    flush_valid  = 1'b0;
    #1;
    id = int'(lk_rsp_id);
    check("rst_lk_valid", lk_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_flush_ready", flush_ready, 0);
    check("rst_lk_flush_valid", lk_flush_valid, 0);
    check("rst_lk_rsp_ready", lk_rsp_ready,
          id < N ? rsp_ready[id] : 1'b1);
    @(negedge clk);
    req_valid    = '0;
    lk_rsp_valid = 1'b0;
    rst_n        = 1'b1;
    model_reset();
  endtask

  task automatic cycle(int p_rsp);
    int g, ev, r, id;
    logic [N-1:0] e_rr, e_rv;
    logic e_lrr, e_fr;
    int n_inf, n_held, n_phase;
    @(negedge clk);
    for (int p = 0; p < N; p++)
      req_valid[p] = (held == p) || ($urandom_range(0, 99) < 60);
    req_addr     = {$urandom(), $urandom(), $urandom()};
    lk_ready     = $urandom_range(0, 99) < 70;
    lk_rsp_valid = inflight > 0 && $urandom_range(0, 99) < p_rsp;
    r            = $urandom_range(0, 9);
    lk_rsp_id    = IW'(r == 0 ? 3 : (r == 1 ? 2 : r % 2));
    lk_rsp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    lk_rsp_hit   = $urandom_range(0, 1) == 1;
    lk_rsp_error = $urandom_range(0, 1) == 1;
    rsp_ready    = N'($urandom);
    if (!flush_pend && $urandom_range(0, 99) < 3) flush_pend = 1;
    flush_valid    = flush_pend;
    lk_flush_ready = $urandom_range(0, 1) == 1;
    #1;
    // expected grant
    g = -1; ev = 0;
    if (held >= 0) begin
      g = held; ev = 1;
    end else if (phase == 0 && inflight < MO) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
      ev = (g >= 0);
    end
    e_rr = '0;
    if (ev && lk_ready) e_rr[g] = 1'b1;
    id = int'(lk_rsp_id);
    e_rv = '0;
    e_lrr = 1'b1;
    if (id < N) begin
      e_rv[id] = lk_rsp_valid;
      e_lrr    = rsp_ready[id];
    end
    e_fr = (phase == 2) && lk_flush_ready;
    check("lk_valid", lk_valid, ev);
    if (ev) begin
      check("lk_id", lk_id, g);
      check("lk_addr", lk_addr, req_addr[g*AW +: AW]);
    end
    check("req_ready", req_ready, e_rr);
    check("rsp_valid", rsp_valid, e_rv);
    check("lk_rsp_ready", lk_rsp_ready, e_lrr);
    if (lk_rsp_valid)
      check("rsp_payload", {rsp_data, rsp_hit, rsp_error},
            {lk_rsp_data, lk_rsp_hit, lk_rsp_error});
    check("lk_flush_valid", lk_flush_valid, phase == 2);
    check("flush_ready", flush_ready, e_fr);
    // advance model
    n_inf = inflight + ((ev && lk_ready) ? 1 : 0)
                     - ((lk_rsp_valid && e_lrr) ? 1 : 0);
    n_held = (ev && !lk_ready) ? g : -1;
    n_phase = phase;
    case (phase)
      0: if (flush_valid) n_phase = 1;
      1: if (held < 0 && inflight == 0) n_phase = 2;
      default: if (lk_flush_ready) n_phase = 0;
    endcase
    @(posedge clk);
    if (ev && lk_ready) rr = (g + 1) % N;
    inflight = n_inf;
    held     = n_held;
    phase    = n_phase;
    if (e_fr) flush_pend = 0;
  endtask

  initial begin
    model_reset();
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      repeat (250)
        cycle(blk % 3 == 0 ? 10 : (blk % 3 == 1 ? 50 : 90));
      if (blk == 5) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
